change_dispenser: RTL and testbench
===================================

# change_dispenser

Output-side companion to the coin-accepting vending controller: consumes its `give_nickel` / `give_dime` / `give_doubledime` / `deliver` command pulses, queues them, and drives the physical coin-ejector solenoids and vend motor. It sequences one actuation at a time and confirms each coin through a drop sensor. It sits between the vending controller FSM and the mechanism I/O pads.

## Interface
Parameters:
- `PULSE_CYCLES`, 4, solenoid/vend actuation length in clocks (≥1)
- `GAP_CYCLES`, 2, idle clocks after each actuation (≥1)
- `TIMEOUT_CYCLES`, 16, max clocks to wait for `coin_drop`
- `CNT_W`, 4, width of each pending-coin counter

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `give_nickel` in 1: queue one nickel
- `give_dime` in 1: queue one dime
- `give_doubledime` in 1: queue two dimes
- `deliver` in 1: queue one vend
- `coin_drop` in 1: drop-sensor pulse, one coin confirmed
- `eject_nickel` out 1: nickel solenoid drive
- `eject_dime` out 1: dime solenoid drive
- `vend` out 1: vend motor drive
- `busy` out 1: work pending or in progress
- `fault` out 1: sticky error

## Operation
- Counters `nickel_pending` and `dime_pending` (CNT_W, unsigned), plus flag `vend_pending`.
- Each edge: `nickel_pending += give_nickel`; `dime_pending += give_dime + 2*give_doubledime`; `deliver` sets `vend_pending`. All inputs may be asserted in the same cycle; all are honoured.
- Same-cycle enqueue and dequeue on one counter: the net result is applied.
- Overflow: if the new value would exceed 2^CNT_W−1, the counter saturates and the block enters FAULT.
- States: IDLE, EJECT, WAIT_DROP, GAP, VEND, FAULT.
- IDLE priority: `dime_pending>0` → EJECT(dime), decrement dime; else `nickel_pending>0` → EJECT(nickel), decrement nickel; else `vend_pending` → VEND, clear flag. The vend therefore always follows all queued change.
- EJECT: drives the selected `eject_*` for PULSE_CYCLES, then goes to WAIT_DROP.
- WAIT_DROP: a `coin_drop` high → GAP. If TIMEOUT_CYCLES clocks pass without `coin_drop` → FAULT. `coin_drop` outside WAIT_DROP is ignored.
- VEND: drives `vend` for PULSE_CYCLES, then goes to GAP (no sensor).
- GAP: all drives low for GAP_CYCLES, then IDLE.
- FAULT: all drives low; counters frozen; inputs ignored; `fault`=1 until reset.
- `busy` = (state≠IDLE) or any counter≠0 or `vend_pending`.

## Timing
- Reset values: all outputs 0, counters 0, `vend_pending`=0, state IDLE.
- Asserting `reset` mid-actuation drops every drive output immediately (asynchronously) and discards the queue.
- Outputs are Moore, decoded from the registered state and the registered denomination; there are no combinational paths from inputs to outputs.
- Latency from a `give_dime` sampled at edge k in IDLE with an empty queue:
  - counter = 1 after edge k
  - EJECT entered at edge k+1
  - `eject_dime` high for edges k+1 … k+PULSE_CYCLES
- `coin_drop` sampled high at a WAIT_DROP edge → GAP at that edge.
- Minimum spacing between actuations: PULSE + 1 + GAP + 1 cycles.
- Timeout: WAIT_DROP entered at edge w with no drop → FAULT at edge w+TIMEOUT_CYCLES.

## Structure
- `change_dispenser_pkg`: state enum `disp_state_t`, denomination enum `denom_t` {DENOM_NICKEL, DENOM_DIME}, and the cents constants NICKEL=5, DIME=10.
- One sub-module, `dispense_timer`: a loadable down-counter with a `done` flag, shared by the EJECT, WAIT_DROP, GAP and VEND states. Its width is $clog2 of the max of the timing parameters, plus 1.

## Test plan
1. Hold `reset` low, then release with no input → all outputs 0, `busy`=0 for 20 cycles.
2. One `give_dime` pulse; `coin_drop` on the 3rd WAIT_DROP cycle → `eject_dime` high exactly 4 cycles, then GAP of 2 cycles, then IDLE; `busy` falls.
3. `give_nickel`, `give_dime`, `give_doubledime` and `deliver` all in one cycle; each eject acknowledged → order dime, dime, dime, nickel, vend; each drive 4 cycles wide.
4. `give_nickel` with no `coin_drop` → `fault`=1 exactly 16 cycles after WAIT_DROP entry; a later `give_dime` produces no eject.
5. 16 `give_dime` pulses while the first eject is stalled → counter saturates at 15 and `fault` asserts.
6. `reset` asserted during the 2nd cycle of `eject_dime` → `eject_dime` drops without waiting for a clock edge; after release, `busy`=0.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared types and constants for the change dispenser
package change_dispenser_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EJECT,
      S_WAIT_DROP,
      S_GAP,
      S_VEND,
      S_FAULT
   } disp_state_t;

   typedef enum logic {
      DENOM_NICKEL,
      DENOM_DIME
   } denom_t;

   localparam int NICKEL = 5;
   localparam int DIME   = 10;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dispense_timer.sv
// rtl/dispense_timer.sv - loadable down-counter shared by all timed dispenser states
// done_o is high whenever the count has reached zero, including right after a load of zero.
module dispense_timer #(
   parameter int W = 5
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - queues change/vend commands and sequences coin solenoids and vend motor
// Dimes drain first, then nickels, then the vend; each coin must be confirmed by coin_drop.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int PULSE_CYCLES   = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic give_nickel,
   input  logic give_dime,
   input  logic give_doubledime,
   input  logic deliver,
   input  logic coin_drop,
   output logic eject_nickel,
   output logic eject_dime,
   output logic vend,
   output logic busy,
   output logic fault
);

   localparam int TMR_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) + 1;
   localparam int EXT_W = CNT_W + 2;
   localparam logic [EXT_W-1:0] CNT_MAX = EXT_W'((1 << CNT_W) - 1);

   disp_state_t      state_q, state_d;
   denom_t           denom_q, denom_d;
   logic [CNT_W-1:0] nickel_q, nickel_d;
   logic [CNT_W-1:0] dime_q, dime_d;
   logic             vend_pend_q, vend_pend_d;

   logic             deq_nickel, deq_dime, deq_vend;
   logic [EXT_W-1:0] nickel_sum, dime_sum;
   logic             overflow;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_done;

   dispense_timer #(
      .W(TMR_W)
   ) u_timer (
      .clk_i     (clock),
      .rst_ni    (reset),
      .load_i    (tmr_load),
      .load_val_i(tmr_load_val),
      .done_o    (tmr_done)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         denom_q     <= DENOM_NICKEL;
         nickel_q    <= '0;
         dime_q      <= '0;
         vend_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         denom_q     <= denom_d;
         nickel_q    <= nickel_d;
         dime_q      <= dime_d;
         vend_pend_q <= vend_pend_d;
      end
   end

   // Enqueue and dequeue on the same edge net out; the queue is frozen once faulted.
   always_comb begin
      deq_dime    = (state_q == S_IDLE) && (dime_q != '0);
      deq_nickel  = (state_q == S_IDLE) && (dime_q == '0) && (nickel_q != '0);
      deq_vend    = (state_q == S_IDLE) && (dime_q == '0) && (nickel_q == '0) && vend_pend_q;
      nickel_sum  = EXT_W'(nickel_q) + EXT_W'(give_nickel) - EXT_W'(deq_nickel);
      dime_sum    = EXT_W'(dime_q) + EXT_W'(give_dime) + EXT_W'({give_doubledime, 1'b0})
                    - EXT_W'(deq_dime);
      overflow    = 1'b0;
      nickel_d    = nickel_q;
      dime_d      = dime_q;
      vend_pend_d = vend_pend_q;
      if (state_q != S_FAULT) begin
         if (nickel_sum > CNT_MAX) begin
            overflow = 1'b1;
            nickel_d = '1;
         end else begin
            nickel_d = nickel_sum[CNT_W-1:0];
         end
         if (dime_sum > CNT_MAX) begin
            overflow = 1'b1;
            dime_d   = '1;
         end else begin
            dime_d = dime_sum[CNT_W-1:0];
         end
         vend_pend_d = (vend_pend_q && !deq_vend) || deliver;
      end
   end

   always_comb begin
      state_d = state_q;
      denom_d = denom_q;
      case (state_q)
         S_IDLE: begin
            if (deq_dime) begin
               state_d = S_EJECT;
               denom_d = DENOM_DIME;
            end else if (deq_nickel) begin
               state_d = S_EJECT;
               denom_d = DENOM_NICKEL;
            end else if (deq_vend) begin
               state_d = S_VEND;
            end
         end
         S_EJECT:     if (tmr_done) state_d = S_WAIT_DROP;
         S_WAIT_DROP: begin
            if (coin_drop) begin
               state_d = S_GAP;
            end else if (tmr_done) begin
               state_d = S_FAULT;
            end
         end
         S_GAP:       if (tmr_done) state_d = S_IDLE;
         S_VEND:      if (tmr_done) state_d = S_GAP;
         S_FAULT:     state_d = S_FAULT;
         default:     state_d = S_FAULT;
      endcase
      if (overflow) begin
         state_d = S_FAULT;
      end

      // The timer is reloaded on every state change with the length of the state being entered.
      tmr_load = (state_d != state_q);
      case (state_d)
         S_EJECT, S_VEND: tmr_load_val = TMR_W'(PULSE_CYCLES - 1);
         S_WAIT_DROP:     tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
         S_GAP:           tmr_load_val = TMR_W'(GAP_CYCLES - 1);
         default:         tmr_load_val = '0;
      endcase
   end

   always_comb begin
      eject_nickel = (state_q == S_EJECT) && (denom_q == DENOM_NICKEL);
      eject_dime   = (state_q == S_EJECT) && (denom_q == DENOM_DIME);
      vend         = (state_q == S_VEND);
      fault        = (state_q == S_FAULT);
      busy         = (state_q != S_IDLE) || (nickel_q != '0) || (dime_q != '0) || vend_pend_q;
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic give_nickel = 1'b0;
   logic give_dime = 1'b0;
   logic give_doubledime = 1'b0;
   logic deliver = 1'b0;
   logic coin_drop = 1'b0;
   logic eject_nickel, eject_dime, vend, busy, fault;

   change_dispenser #(
      .PULSE_CYCLES(4),
      .GAP_CYCLES(2),
      .TIMEOUT_CYCLES(16),
      .CNT_W(4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .give_nickel    (give_nickel),
      .give_dime      (give_dime),
      .give_doubledime(give_doubledime),
      .deliver        (deliver),
      .coin_drop      (coin_drop),
      .eject_nickel   (eject_nickel),
      .eject_dime     (eject_dime),
      .vend           (vend),
      .busy           (busy),
      .fault          (fault)
   );

   always #5 clock = ~clock;

   localparam int K_NICKEL = 0;
   localparam int K_DIME   = 1;
   localparam int K_VEND   = 2;
   localparam int K_FAULT  = 3;
   localparam int K_BUSY   = 4;

   typedef struct {
      int kind;
      int val;
      int lead;
   } ev_t;

   ev_t  sb[$];
   int   tests = 0;
   int   fails = 0;

   int   cyc = 0;
   int   last_fall = 0;
   int   rise_cyc[3];
   int   lead_at[3];
   logic [2:0] drv;
   logic [2:0] prev_drv = 3'b000;
   logic prev_fault = 1'b0;
   logic prev_busy = 1'b0;

   int   drop_delay = 0;
   int   drop_wait = 0;
   logic [1:0] prev_ej = 2'b00;

   task automatic expect_ev(input int k, input int v, input int l);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.lead = l;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic report(input int k, input int v, input int l);
      ev_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d val %0d lead %0d, expected no event", k, v, l);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.val != v || (e.lead >= 0 && e.lead != l)) begin
            fails++;
            $display("FAIL event: got kind %0d val %0d lead %0d, expected kind %0d val %0d lead %0d",
                     k, v, l, e.kind, e.val, e.lead);
         end
      end
   endtask

   // Monitor: drive pulse widths/spacing, fault rise and busy fall, timed in sampled cycles
   always @(negedge clock) begin
      drv = {vend, eject_dime, eject_nickel};
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (drv[d] && !prev_drv[d]) begin
            rise_cyc[d] = cyc;
            lead_at[d]  = cyc - last_fall;
         end
         if (!drv[d] && prev_drv[d]) begin
            report(d, cyc - rise_cyc[d], lead_at[d]);
            last_fall = cyc;
         end
      end
      if (fault && !prev_fault) report(K_FAULT, cyc - last_fall, -1);
      if (!busy && prev_busy && reset) report(K_BUSY, cyc - last_fall, -1);
      prev_drv   = drv;
      prev_fault = fault;
      prev_busy  = busy;
   end

   // Drop sensor: pulses coin_drop so it is sampled drop_delay edges after an eject ends
   always @(negedge clock) begin
      coin_drop = 1'b0;
      if (drop_wait > 0) begin
         if (drop_wait == 1) coin_drop = 1'b1;
         drop_wait--;
      end
      if (((prev_ej[0] && !eject_nickel) || (prev_ej[1] && !eject_dime)) && drop_delay > 0) begin
         if (drop_delay == 1) coin_drop = 1'b1;
         else drop_wait = drop_delay - 1;
      end
      prev_ej = {eject_dime, eject_nickel};
   end

   task automatic wait_sb(input int max_cycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("idle_outputs", int'({eject_nickel, eject_dime, vend, busy, fault}), 0);
      end

      // Single dime, drop on 3rd WAIT_DROP cycle
      drop_delay = 3;
      expect_ev(K_DIME, 4, -1);
      expect_ev(K_BUSY, 5, -1);
      @(negedge clock);
      give_dime = 1'b1;
      @(negedge clock);
      give_dime = 1'b0;
      check("dime_count_after_enqueue", int'(dut.dime_q), 1);
      check("busy_after_enqueue", int'(busy), 1);
      @(negedge clock);
      check("eject_dime_next_edge", int'(eject_dime), 1);
      wait_sb(60);

      // Everything at once: dime x3, nickel, vend
      drop_delay = 1;
      expect_ev(K_DIME, 4, -1);
      expect_ev(K_DIME, 4, 4);
      expect_ev(K_DIME, 4, 4);
      expect_ev(K_NICKEL, 4, 4);
      expect_ev(K_VEND, 4, 4);
      expect_ev(K_BUSY, 2, -1);
      @(negedge clock);
      give_nickel = 1'b1;
      give_dime = 1'b1;
      give_doubledime = 1'b1;
      deliver = 1'b1;
      @(negedge clock);
      give_nickel = 1'b0;
      give_dime = 1'b0;
      give_doubledime = 1'b0;
      deliver = 1'b0;
      wait_sb(200);

      // Drop timeout faults; later commands ignored
      drop_delay = 0;
      expect_ev(K_NICKEL, 4, -1);
      expect_ev(K_FAULT, 16, -1);
      @(negedge clock);
      give_nickel = 1'b1;
      @(negedge clock);
      give_nickel = 1'b0;
      wait_sb(100);
      @(negedge clock);
      give_dime = 1'b1;
      @(negedge clock);
      give_dime = 1'b0;
      repeat (30) @(negedge clock);
      check("fault_sticky", int'(fault), 1);
      check("busy_in_fault", int'(busy), 1);
      do_reset();
      @(negedge clock);
      check("fault_cleared_by_reset", int'({fault, busy}), 0);

      // Dime counter overflow while first eject is stalled
      expect_ev(K_DIME, 4, -1);
      expect_ev(K_FAULT, 11, -1);
      @(negedge clock);
      give_dime = 1'b1;
      repeat (17) @(negedge clock);
      give_dime = 1'b0;
      wait_sb(60);
      check("dime_count_saturated", int'(dut.dime_q), 15);
      check("fault_on_overflow", int'(fault), 1);
      do_reset();

      // Async reset in 2nd eject cycle
      drop_delay = 1;
      expect_ev(K_DIME, 1, -1);
      @(negedge clock);
      give_dime = 1'b1;
      @(negedge clock);
      give_dime = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      check("eject_before_reset", int'(eject_dime), 1);
      #1;
      reset = 1'b0;
      #1;
      check("eject_drops_async", int'(eject_dime), 0);
      wait_sb(10);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("busy_after_reset", int'(busy), 0);
      check("outputs_after_reset", int'({eject_nickel, eject_dime, vend, fault}), 0);
      repeat (5) @(negedge clock);
      check("no_stray_events", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
